switch_allocator: RTL and testbench
===================================

Name: switch_allocator

Overview:
- Per-cycle crossbar scheduler for the router. It runs after VC allocation: each input VC that holds a downstream VC and has a flit at its buffer head requests its output port.
- Two stages, separable input-first, both round-robin: one VC per input port, then one input port per output port.
- Keeps per-downstream-VC credit counters so a flit is never sent into a full downstream buffer.
- Drives crossbar selects and read-enables for the input buffers.

Parameters:
- PORT_NUM, 5, number of router ports (inputs = outputs)
- VC_NUM, 2, virtual channels per port
- BUFFER_SIZE, 8, downstream buffer depth per VC; initial credit count
- VC_SIZE, $clog2(VC_NUM), VC index width
- PORT_SIZE, $clog2(PORT_NUM), port index width
- CNT_SIZE, $clog2(BUFFER_SIZE+1), credit counter width

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- request_i  input  [PORT_NUM][VC_NUM]  input VC has a head flit and an allocated downstream VC
- out_port_i  input  [PORT_NUM][VC_NUM][PORT_SIZE]  output port of each input VC
- downstream_vc_i  input  [PORT_NUM][VC_NUM][VC_SIZE]  downstream VC allocated to each input VC
- credit_valid_i  input  [PORT_NUM]  one credit returned on that output port this cycle
- credit_vc_i  input  [PORT_NUM][VC_SIZE]  downstream VC the credit belongs to
- grant_o  output  [PORT_NUM][VC_NUM]  input VC wins this cycle; at most one bit per input port; pops one flit
- xbar_valid_o  output  [PORT_NUM]  output port carries a flit this cycle
- xbar_sel_o  output  [PORT_NUM][PORT_SIZE]  input port routed to each output port; 0 when not valid
- credit_overflow_o  output  1  sticky error flag

Behaviour:
- Latency: grant_o, xbar_valid_o and xbar_sel_o are combinational from the same-cycle inputs and current state (zero-cycle). Credits and pointers update on the next rising edge.
- While rst=0: grant_o=0, xbar_valid_o=0, xbar_sel_o=0, credit_overflow_o=0.
- Reset values: all credit counters = BUFFER_SIZE; all round-robin pointers = 0. Reset asserted mid-operation discards all in-flight credit state and returns to these values.
- Eligibility: request_i[p][v] counts only if out_port_i[p][v] < PORT_NUM and credit[out_port_i][downstream_vc_i] > 0.
- Input stage: per input port, round-robin over eligible VCs, starting at in_ptr[p]. Gives at most one candidate per input port.
- Output stage: per output port o, round-robin over input ports whose candidate targets o, starting at out_ptr[o].
  - Winner: xbar_valid_o[o]=1, xbar_sel_o[o]=winning input port, grant_o[winner][vc]=1.
- Pointer update on each output-stage win:
  - out_ptr[o] = winning input + 1, wrapping modulo PORT_NUM.
  - in_ptr[winning input] = winning VC + 1, wrapping modulo VC_NUM.
- Pointers of input ports that lost the output stage are unchanged, so the same VC retries next cycle.
- Credit counter credit[o][d], per edge:
  - grant to (o,d) only: decrement by 1.
  - credit return to (o,d) only: increment by 1.
  - grant and return in the same cycle: unchanged.
  - neither: unchanged.
- Credit = 0: VC is ineligible; the counter never underflows.
- Credit return with counter = BUFFER_SIZE and no simultaneous grant: counter holds at BUFFER_SIZE and credit_overflow_o sets to 1. It stays 1 until reset.
- Invariants:
  - At most one grant per input port and at most one per output port.
  - grant_o is nonzero only if the matching request_i bit is high.

Test Plan:
- Single request, PORT_NUM=5, VC_NUM=2: request_i[1][0]=1, out_port=3, downstream_vc=1 -> same cycle grant_o[1][0]=1, xbar_valid_o[3]=1, xbar_sel_o[3]=1. credit[3][1] reads 7 after the edge.
- Credit exhaustion, BUFFER_SIZE=8: hold the request above with no returns -> grants in 8 consecutive cycles, then grant_o=0. One credit_valid_i[3] with credit_vc_i=1 -> exactly one further grant.
- Output contention: inputs 0 and 2 both request output 4 every cycle with ample credits -> xbar_sel_o[4] follows 0,2,0,2, one grant per cycle.
- Input-stage fairness: input 1 VC0 to output 0 and VC1 to output 2, both eligible -> grants alternate VC0, VC1 each cycle. Output 0 and output 2 are valid on alternate cycles.
- Simultaneous grant and return on the same (o,d) at credit=5 -> credit still 5 after the edge. A return at credit=8 with no grant -> credit_overflow_o=1 and sticky.
- Reset mid-traffic: drop rst to 0 with credit[3][1]=2 -> outputs 0 immediately. After release, credit reads 8 and all pointers are 0 (first contention winner is the lowest index).

Source files
------------

// File: rtl/switch_allocator.sv
// Separable input-first round-robin switch allocator with per-downstream-VC credit tracking.
// Latency: grants and crossbar selects are combinational (same cycle); credits and pointers update on the next edge.
// Backpressure: a VC whose downstream buffer has zero credits cannot request, so the downstream buffer never overflows.
module switch_allocator #(
    parameter int PORT_NUM    = 5,
    parameter int VC_NUM      = 2,
    parameter int BUFFER_SIZE = 8,
    parameter int VC_SIZE     = $clog2(VC_NUM),
    parameter int PORT_SIZE   = $clog2(PORT_NUM),
    parameter int CNT_SIZE    = $clog2(BUFFER_SIZE + 1)
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]                request_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_SIZE-1:0] out_port_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0]   downstream_vc_i,
    input  logic [PORT_NUM-1:0]                            credit_valid_i,
    input  logic [PORT_NUM-1:0][VC_SIZE-1:0]               credit_vc_i,
    output logic [PORT_NUM-1:0][VC_NUM-1:0]                grant_o,
    output logic [PORT_NUM-1:0]                            xbar_valid_o,
    output logic [PORT_NUM-1:0][PORT_SIZE-1:0]             xbar_sel_o,
    output logic                                           credit_overflow_o
);

    localparam logic [CNT_SIZE-1:0] CREDIT_FULL = CNT_SIZE'(BUFFER_SIZE);

    logic [PORT_NUM-1:0][VC_NUM-1:0][CNT_SIZE-1:0] credit_q, credit_d;
    logic [PORT_NUM-1:0][VC_SIZE-1:0]              in_ptr_q, in_ptr_d;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0]            out_ptr_q, out_ptr_d;
    logic                                          overflow_q, overflow_d;

    logic [PORT_NUM-1:0][VC_NUM-1:0]    elig;
    logic [PORT_NUM-1:0]                cand_vld;
    logic [PORT_NUM-1:0][VC_SIZE-1:0]   cand_vc;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0] cand_port;
    logic [PORT_NUM-1:0][VC_NUM-1:0]    grant;
    logic [PORT_NUM-1:0]                xbar_vld;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0] xbar_sel;

    // Out-of-range port or VC indices never become eligible.
    always_comb begin
        elig = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (request_i[p][v] && (int'(out_port_i[p][v]) < PORT_NUM) &&
                    (int'(downstream_vc_i[p][v]) < VC_NUM)) begin
                    if (credit_q[out_port_i[p][v]][downstream_vc_i[p][v]] != '0) begin
                        elig[p][v] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        cand_vld  = '0;
        cand_vc   = '0;
        cand_port = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            for (int k = 0; k < VC_NUM; k++) begin
                if (!cand_vld[p] && elig[p][(int'(in_ptr_q[p]) + k) % VC_NUM]) begin
                    cand_vld[p] = 1'b1;
                    cand_vc[p]  = VC_SIZE'((int'(in_ptr_q[p]) + k) % VC_NUM);
                end
            end
            cand_port[p] = out_port_i[p][cand_vc[p]];
        end
    end

    // Only winners advance pointers; a losing input keeps its VC pointer and retries.
    always_comb begin
        grant     = '0;
        xbar_vld  = '0;
        xbar_sel  = '0;
        out_ptr_d = out_ptr_q;
        in_ptr_d  = in_ptr_q;
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int k = 0; k < PORT_NUM; k++) begin
                int i;
                i = (int'(out_ptr_q[o]) + k) % PORT_NUM;
                if (!xbar_vld[o] && cand_vld[i] && (int'(cand_port[i]) == o)) begin
                    xbar_vld[o]         = 1'b1;
                    xbar_sel[o]         = PORT_SIZE'(i);
                    grant[i][cand_vc[i]] = 1'b1;
                    out_ptr_d[o]        = PORT_SIZE'((i + 1) % PORT_NUM);
                    in_ptr_d[i]         = VC_SIZE'((int'(cand_vc[i]) + 1) % VC_NUM);
                end
            end
        end
    end

    always_comb begin
        credit_d   = credit_q;
        overflow_d = overflow_q;
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int d = 0; d < VC_NUM; d++) begin
                logic dec;
                logic inc;
                dec = xbar_vld[o] &&
                      (downstream_vc_i[xbar_sel[o]][cand_vc[xbar_sel[o]]] == VC_SIZE'(d));
                inc = credit_valid_i[o] && (credit_vc_i[o] == VC_SIZE'(d));
                if (dec && !inc) begin
                    credit_d[o][d] = credit_q[o][d] - CNT_SIZE'(1);
                end else if (inc && !dec) begin
                    if (credit_q[o][d] == CREDIT_FULL) begin
                        overflow_d = 1'b1;
                    end else begin
                        credit_d[o][d] = credit_q[o][d] + CNT_SIZE'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit_q   <= {(PORT_NUM * VC_NUM){CREDIT_FULL}};
            in_ptr_q   <= '0;
            out_ptr_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            credit_q   <= credit_d;
            in_ptr_q   <= in_ptr_d;
            out_ptr_q  <= out_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    assign grant_o           = rst ? grant    : '0;
    assign xbar_valid_o      = rst ? xbar_vld : '0;
    assign xbar_sel_o        = rst ? xbar_sel : '0;
    assign credit_overflow_o = overflow_q;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench: each cycle's expected outputs are queued by the driver and popped by a monitor.
module tb_switch_allocator;

    logic                  clk;
    logic                  rst;
    logic [4:0][1:0]       request_i;
    logic [4:0][1:0][2:0]  out_port_i;
    logic [4:0][1:0][0:0]  downstream_vc_i;
    logic [4:0]            credit_valid_i;
    logic [4:0][0:0]       credit_vc_i;
    logic [4:0][1:0]       grant_o;
    logic [4:0]            xbar_valid_o;
    logic [4:0][2:0]       xbar_sel_o;
    logic                  credit_overflow_o;

    switch_allocator #(.PORT_NUM(5), .VC_NUM(2), .BUFFER_SIZE(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .request_i         (request_i),
        .out_port_i        (out_port_i),
        .downstream_vc_i   (downstream_vc_i),
        .credit_valid_i    (credit_valid_i),
        .credit_vc_i       (credit_vc_i),
        .grant_o           (grant_o),
        .xbar_valid_o      (xbar_valid_o),
        .xbar_sel_o        (xbar_sel_o),
        .credit_overflow_o (credit_overflow_o)
    );

    typedef struct {
        string           nm;
        logic [4:0][1:0] g;
        logic [4:0]      xv;
        logic [4:0][2:0] sel;
        logic            ov;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    logic [4:0][1:0] e_g;
    logic [4:0]      e_xv;
    logic [4:0][2:0] e_sel;
    logic            e_ov;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (grant_o !== e.g || xbar_valid_o !== e.xv || xbar_sel_o !== e.sel ||
                credit_overflow_o !== e.ov) begin
                errors++;
                $display("FAIL %s: got grant=%h valid=%h sel=%h ovf=%b, expected grant=%h valid=%h sel=%h ovf=%b",
                         e.nm, grant_o, xbar_valid_o, xbar_sel_o, credit_overflow_o,
                         e.g, e.xv, e.sel, e.ov);
            end
        end
    end

    task automatic clr_in();
        request_i       = '0;
        out_port_i      = '0;
        downstream_vc_i = '0;
        credit_valid_i  = '0;
        credit_vc_i     = '0;
    endtask

    task automatic setreq(input int p, input int v, input int op, input int dvc);
        request_i[p][v]       = 1'b1;
        out_port_i[p][v]      = 3'(op);
        downstream_vc_i[p][v] = 1'(dvc);
    endtask

    task automatic ex0();
        e_g   = '0;
        e_xv  = '0;
        e_sel = '0;
    endtask

    task automatic eg(input int p, input int v, input int o);
        e_g[p][v] = 1'b1;
        e_xv[o]   = 1'b1;
        e_sel[o]  = 3'(p);
    endtask

    task automatic cyc(input string nm);
        exp_t e;
        e.nm  = nm;
        e.g   = e_g;
        e.xv  = e_xv;
        e.sel = e_sel;
        e.ov  = e_ov;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst  = 1'b0;
        e_ov = 1'b0;
        clr_in();
        ex0();
        @(posedge clk);
        #1;

        // Outputs forced low during reset even with a live request
        setreq(1, 0, 3, 1);
        cyc("rst_hold");
        cyc("rst_hold2");
        rst = 1'b1;

        // Single request: eight grants exhaust credit[3][1]
        for (int i = 0; i < 8; i++) begin
            ex0(); eg(1, 0, 3); cyc("exhaust");
        end
        ex0(); cyc("credit_empty");
        credit_valid_i[3] = 1'b1; credit_vc_i[3] = 1'b1;
        ex0(); cyc("return_cycle");
        credit_valid_i = '0;
        ex0(); eg(1, 0, 3); cyc("one_more");
        ex0(); cyc("empty_again");
        clr_in();

        // Output port out of range never wins
        setreq(3, 1, 6, 0);
        ex0(); cyc("bad_port");
        clr_in();

        // Input-stage round robin; in_ptr[1] is 1 after the grants above
        setreq(1, 0, 0, 0);
        setreq(1, 1, 2, 0);
        for (int i = 0; i < 4; i++) begin
            ex0();
            if (i % 2 == 0) eg(1, 1, 2);
            else            eg(1, 0, 0);
            cyc("in_rr");
        end
        clr_in();

        // Output-stage round robin on output 4: 0,2,0,2,0
        setreq(0, 0, 4, 0);
        setreq(2, 0, 4, 1);
        for (int i = 0; i < 5; i++) begin
            ex0(); eg((i % 2 == 1) ? 2 : 0, 0, 4); cyc("out_rr");
        end
        clr_in();

        // credit[4][0] is 5: grant+return keeps 5, then exactly five more grants
        setreq(0, 0, 4, 0);
        credit_valid_i[4] = 1'b1; credit_vc_i[4] = 1'b0;
        ex0(); eg(0, 0, 4); cyc("grant_and_return");
        credit_valid_i = '0;
        for (int i = 0; i < 5; i++) begin
            ex0(); eg(0, 0, 4); cyc("drain5");
        end
        ex0(); cyc("drained");
        clr_in();

        // Return into a full counter sets the sticky overflow flag
        credit_valid_i[1] = 1'b1; credit_vc_i[1] = 1'b0;
        ex0(); cyc("ovf_edge");
        credit_valid_i = '0;
        e_ov = 1'b1;
        ex0(); cyc("ovf_set");
        ex0(); cyc("ovf_sticky");

        // Bring credit[3][1] from 0 to 2
        credit_valid_i[3] = 1'b1; credit_vc_i[3] = 1'b1;
        ex0(); cyc("refill");
        ex0(); cyc("refill");
        clr_in();

        // Mid-traffic reset: out_ptr[4] is 1 and credit[3][1] is 2 beforehand
        setreq(1, 0, 3, 1);
        setreq(0, 0, 4, 0);
        setreq(2, 0, 4, 1);
        rst  = 1'b0;
        e_ov = 1'b0;
        ex0(); cyc("rst_mid");
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ex0(); eg(1, 0, 3); eg((i % 2 == 1) ? 2 : 0, 0, 4); cyc("post_rst");
        end
        ex0(); eg(0, 0, 4); cyc("post_rst_cr8");
        clr_in();

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
